lsu_ctrl: RTL

LSU_CTRL -- requirements
Module: lsu_ctrl

---
 rtl/lsu_pkg.sv | 39 +++
 rtl/lsu_align.sv | 54 +++++
 rtl/lsu_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared constants for the load/store unit: funct3 codes, FSM states,
// RAM size and the access legality check.
package lsu_pkg;

   localparam int RAM_WORDS = 1024;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE,
      RD,
      WR,
      RESP
   } state_t;

   // Unsigned variants only exist for loads.
   function automatic logic is_legal(
      input logic        we,
      input logic [2:0]  f3,
      input logic [31:0] addr
   );
      logic ok;
      ok = addr < 32'(RAM_WORDS * 4);
      case (f3)
         F3_B:    ok = ok;
         F3_H:    ok = ok && !addr[0];
         F3_W:    ok = ok && (addr[1:0] == 2'b00);
         F3_BU:   ok = ok && !we;
         F3_HU:   ok = ok && !we && !addr[0];
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational data alignment: load byte/half extract with sign or zero
// extension, and store byte/half merge into a read-back word.
//   f3, off   : latched funct3 and addr[1:0]
//   word      : RAM word (live read data or buffered copy)
//   wdata     : right-aligned store data
//   ld_data   : extended load result
//   st_data   : word to write back
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  f3,
   input  logic [1:0]  off,
   input  logic [31:0] word,
   input  logic [31:0] wdata,
   output logic [31:0] ld_data,
   output logic [31:0] st_data
);

   logic [7:0]  b;
   logic [15:0] h;

   always_comb begin
      b = word[8*off +: 8];
      h = off[1] ? word[31:16] : word[15:0];
   end

   always_comb begin
      ld_data = word;
      case (f3)
         F3_B:    ld_data = {{24{b[7]}}, b};
         F3_BU:   ld_data = {24'h0, b};
         F3_H:    ld_data = {{16{h[15]}}, h};
         F3_HU:   ld_data = {16'h0, h};
         default: ld_data = word;
      endcase
   end

   always_comb begin
      st_data = wdata;
      case (f3)
         F3_B: begin
            st_data = word;
            st_data[8*off +: 8] = wdata[7:0];
         end
         F3_H: begin
            st_data = word;
            if (off[1]) st_data[31:16] = wdata[15:0];
            else        st_data[15:0]  = wdata[15:0];
         end
         default: st_data = wdata;
      endcase
   end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller in front of a 1024-word RAM with combinational read.
// CPU side: clk, rst, req, we, funct3, addr, wdata -> busy, done, err, rdata.
// RAM side: mem_re, mem_we, mem_a, mem_wd -> mem_rd.
// Sub-word stores do read-modify-write (RD then WR); SW writes directly.
module lsu_ctrl
   import lsu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        we,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [31:0] rdata,
   output logic        mem_re,
   output logic        mem_we,
   output logic [31:0] mem_a,
   output logic [31:0] mem_wd,
   input  logic [31:0] mem_rd
);

   state_t      state;
   logic        we_q;
   logic [2:0]  f3_q;
   logic [1:0]  off_q;
   logic [31:0] wdata_q;
   logic [31:0] buf_q;
   logic [31:0] word;
   logic [31:0] ld_data;
   logic [31:0] st_data;

   // Loads extract straight from the RAM during RD; the merge in WR
   // works from the word buffered at the end of RD.
   assign word = (state == RD) ? mem_rd : buf_q;

   lsu_align u_align (
      .f3      (f3_q),
      .off     (off_q),
      .word    (word),
      .wdata   (wdata_q),
      .ld_data (ld_data),
      .st_data (st_data)
   );

   // Gated by state so a reset during WR clears it with the state.
   assign mem_wd = (state == WR) ? st_data : 32'h0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         we_q    <= 1'b0;
         f3_q    <= 3'b0;
         off_q   <= 2'b0;
         wdata_q <= 32'h0;
         buf_q   <= 32'h0;
         busy    <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
         rdata   <= 32'h0;
         mem_re  <= 1'b0;
         mem_we  <= 1'b0;
         mem_a   <= 32'h0;
      end else begin
         unique case (state)
            IDLE: begin
               if (req) begin
                  we_q    <= we;
                  f3_q    <= funct3;
                  off_q   <= addr[1:0];
                  wdata_q <= wdata;
                  busy    <= 1'b1;
                  if (!is_legal(we, funct3, addr)) begin
                     state <= RESP;
                     done  <= 1'b1;
                     err   <= 1'b1;
                     rdata <= 32'h0;
                  end else begin
                     err   <= 1'b0;
                     mem_a <= {2'b00, addr[31:2]};
                     if (we && funct3 == F3_W) begin
                        state  <= WR;
                        mem_we <= 1'b1;
                     end else begin
                        state  <= RD;
                        mem_re <= 1'b1;
                     end
                  end
               end
            end
            RD: begin
               buf_q  <= mem_rd;
               mem_re <= 1'b0;
               if (we_q) begin
                  state  <= WR;
                  mem_we <= 1'b1;
               end else begin
                  state <= RESP;
                  mem_a <= 32'h0;
                  done  <= 1'b1;
                  rdata <= ld_data;
               end
            end
            WR: begin
               mem_we <= 1'b0;
               mem_a  <= 32'h0;
               state  <= RESP;
               done   <= 1'b1;
               rdata  <= 32'h0;
            end
            RESP: begin
               done  <= 1'b0;
               err   <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
